// File: rtl/gen_nonlinear_stream.sv
// Streams the adder carry-chain monomials one bit-position block per handshake,
// together with each position's carry-out and sum bit (a self-checking serial adder).
module gen_nonlinear_stream #(
    parameter int NBIT = 7,
    parameter int NBLK = NBIT,
    parameter int WMAX = 2**(NBLK+1)-1,
    parameter int CW   = $clog2(WMAX+1),
    parameter int IW   = (NBLK > 1) ? $clog2(NBLK) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WMAX-1:0] out_terms,
    output logic [CW-1:0]   out_count,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic            out_carry,
    output logic            out_sum
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [NBIT-1:0] a_r, b_r;
    logic [WMAX-1:0] prev;
    logic [CW-1:0]   prev_count;
    logic [IW-1:0]   idx;

    logic            run, fire, last, aj, bj;
    logic [CW-1:0]   count, sh;
    logic [WMAX-1:0] mask, terms;

    assign run      = (state == RUN);
    assign in_ready = (state == IDLE);
    assign last     = run && (idx == IW'(NBLK-1));
    assign fire     = run && out_ready;

    assign aj = a_r[idx];
    assign bj = b_r[idx];

    // prev holds exactly prev_count = 2**(j+1)-1 live bits (upper bits are 0),
    // so the b-part starts at bit prev_count+1 and the a-part at bit 1.
    assign count = {prev_count[CW-2:0], 1'b1};
    assign sh    = prev_count + CW'(1);
    assign mask  = (WMAX'(1) << count) - WMAX'(1);
    assign terms = (WMAX'(aj & bj) | ((aj ? prev : '0) << 1) | ((bj ? prev : '0) << sh)) & mask;

    assign out_valid = run;
    assign out_terms = run ? terms : '0;
    assign out_count = run ? count : '0;
    assign out_idx   = idx;
    assign out_last  = last;
    assign out_carry = run & (^terms);
    assign out_sum   = run & (aj ^ bj ^ (^prev));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (out_ready && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            prev       <= '0;
            prev_count <= '0;
            idx        <= '0;
        end else if (in_ready && in_valid) begin
            a_r        <= a;
            b_r        <= b;
            prev       <= WMAX'(c);
            prev_count <= CW'(1);
            idx        <= '0;
        end else if (fire) begin
            if (last) begin
                idx <= '0;
            end else begin
                prev       <= terms;
                prev_count <= count;
                idx        <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gen_nonlinear_stream.sv
// Bench for gen_nonlinear_stream: a 4/4 instance for directed cases and a 7/6
// instance for randomized runs, both scored against a monomial-list model.
module tb_gen_nonlinear_stream;

    logic clk, rst;

    logic        in_valid4, in_ready4, c4, out_valid4, out_ready4, last4, carry4, sum4;
    logic [3:0]  a4, b4;
    logic [30:0] terms4;
    logic [4:0]  count4;
    logic [1:0]  idx4;

    logic         in_valid7, in_ready7, c7, out_valid7, out_ready7, last7, carry7, sum7;
    logic [6:0]   a7, b7;
    logic [126:0] terms7;
    logic [6:0]   count7;
    logic [2:0]   idx7;

    gen_nonlinear_stream #(.NBIT(4), .NBLK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .c(c4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_terms(terms4), .out_count(count4), .out_idx(idx4), .out_last(last4),
        .out_carry(carry4), .out_sum(sum4));

    gen_nonlinear_stream #(.NBIT(7), .NBLK(6)) dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7),
        .a(a7), .b(b7), .c(c7), .out_valid(out_valid7), .out_ready(out_ready7),
        .out_terms(terms7), .out_count(count7), .out_idx(idx7), .out_last(last7),
        .out_carry(carry7), .out_sum(sum7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] terms;
        int           count;
        int           idx;
        bit           last, carry, sum, ar_sum, ar_carry;
    } exp_t;

    exp_t q4[$];
    exp_t q7[$];
    exp_t e4, e7;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    // Reference: expand the carry recurrence as explicit monomial lists, and
    // cross-check sum/carry against plain integer addition.
    task automatic gen(input int nb, input logic [6:0] a, input logic [6:0] b, input logic c, input bit to7);
        bit   prev[$];
        bit   nw[$];
        bit   par;
        exp_t e;
        int   tot, lo;
        prev.delete();
        prev.push_back(c);
        tot = int'(a) + int'(b) + int'(c);
        for (int j = 0; j < nb; j++) begin
            nw.delete();
            nw.push_back(a[j] & b[j]);
            foreach (prev[k]) nw.push_back(a[j] & prev[k]);
            foreach (prev[k]) nw.push_back(b[j] & prev[k]);
            e.terms = '0;
            foreach (nw[k]) e.terms[k] = nw[k];
            e.count = nw.size();
            e.idx   = j;
            e.last  = (j == nb-1);
            par = 0; foreach (nw[k])   par ^= nw[k];   e.carry = par;
            par = 0; foreach (prev[k]) par ^= prev[k]; e.sum = a[j] ^ b[j] ^ par;
            e.ar_sum = tot[j];
            lo = (1 << (j+1)) - 1;
            e.ar_carry = ((((int'(a) & lo) + (int'(b) & lo) + int'(c)) >> (j+1)) & 1) != 0;
            if (to7) q7.push_back(e);
            else     q4.push_back(e);
            prev = nw;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid4) begin
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d4.unexpected idx %0d", idx4);
                end else begin
                    e4 = q4[0];
                    chk("d4.terms", terms4, e4.terms);
                    chk("d4.count", count4, e4.count);
                    chk("d4.idx", idx4, e4.idx);
                    chk("d4.last", last4, e4.last);
                    chk("d4.carry", carry4, e4.carry);
                    chk("d4.sum", sum4, e4.sum);
                    chk("d4.arith_sum", sum4, e4.ar_sum);
                    chk("d4.arith_carry", carry4, e4.ar_carry);
                    chk("d4.in_ready_busy", in_ready4, 0);
                    if (out_ready4) void'(q4.pop_front());
                end
            end
            if (out_valid7) begin
                if (q7.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d7.unexpected idx %0d", idx7);
                end else begin
                    e7 = q7[0];
                    chk("d7.terms", terms7, e7.terms);
                    chk("d7.count", count7, e7.count);
                    chk("d7.idx", idx7, e7.idx);
                    chk("d7.last", last7, e7.last);
                    chk("d7.carry", carry7, e7.carry);
                    chk("d7.sum", sum7, e7.sum);
                    chk("d7.arith_sum", sum7, e7.ar_sum);
                    chk("d7.arith_carry", carry7, e7.ar_carry);
                    chk("d7.in_ready_busy", in_ready7, 0);
                    if (out_ready7) void'(q7.pop_front());
                end
            end
        end
    end

    // Returns at posedge+1 of the accept edge, i.e. while block 0 is presented.
    task automatic acc4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 100) begin @(negedge clk); n++; end
        if (!in_ready4) tmo("d4.accept");
        in_valid4 = 1'b1; a4 = a; b4 = b; c4 = c;
        gen(4, 7'(a), 7'(b), c, 1'b0);
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
    endtask

    task automatic acc7(input logic [6:0] a, input logic [6:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (!in_ready7 && n < 100) begin @(negedge clk); n++; end
        if (!in_ready7) tmo("d7.accept");
        in_valid7 = 1'b1; a7 = a; b7 = b; c7 = c;
        gen(6, a, b, c, 1'b1);
        @(posedge clk); #1;
        in_valid7 = 1'b0; a7 = 7'($urandom); b7 = 7'($urandom); c7 = 1'($urandom);
    endtask

    task automatic lit4(input int j, input logic [30:0] t, input int cnt, input bit cy, input bit sm);
        @(negedge clk);
        chk("lit.valid", out_valid4, 1);
        chk("lit.idx", idx4, j);
        chk("lit.terms", terms4, t);
        chk("lit.count", count4, cnt);
        chk("lit.carry", carry4, cy);
        chk("lit.sum", sum4, sm);
        chk("lit.last", last4, j == 3);
    endtask

    // Random backpressure plus spurious in_valid/operand churn while running.
    task automatic drain4();
        int n = 0;
        bit done = 0;
        while (!done && n < 200) begin
            out_ready4 = ($urandom_range(0, 3) != 0);
            in_valid4  = 1'($urandom);
            a4 = 4'($urandom);
            @(negedge clk);
            if (out_valid4 && out_ready4 && last4) done = 1;
            @(posedge clk); #1;
            n++;
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        if (!done) tmo("d4.drain");
        else chk("d4.in_ready_after_last", in_ready4, 1);
    endtask

    task automatic drain7();
        int n = 0;
        bit done = 0;
        while (!done && n < 200) begin
            out_ready7 = ($urandom_range(0, 3) != 0);
            in_valid7  = 1'($urandom);
            a7 = 7'($urandom);
            @(negedge clk);
            if (out_valid7 && out_ready7 && last7) done = 1;
            @(posedge clk); #1;
            n++;
        end
        in_valid7 = 1'b0; out_ready7 = 1'b1;
        if (!done) tmo("d7.drain");
        else chk("d7.in_ready_after_last", in_ready7, 1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        in_valid4 = 0; a4 = 0; b4 = 0; c4 = 0; out_ready4 = 1;
        in_valid7 = 0; a7 = 0; b7 = 0; c7 = 0; out_ready7 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", in_ready4, 1);
        chk("rst.valid", out_valid4, 0);
        chk("rst.terms", terms4, 0);
        chk("rst.count", count4, 0);
        chk("rst.idx", idx4, 0);
        chk("rst.last", last4, 0);
        chk("rst.carry", carry4, 0);
        chk("rst.sum", sum4, 0);
        chk("rst.d7_ready", in_ready7, 1);
        chk("rst.d7_valid", out_valid7, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1 + 1: single carry out of bit 0
        acc4(4'h1, 4'h1, 1'b0);
        lit4(0, 31'h1, 3, 1, 0);
        lit4(1, 31'h0, 7, 0, 1);
        lit4(2, 31'h0, 15, 0, 0);
        lit4(3, 31'h0, 31, 0, 0);
        @(posedge clk); #1;
        chk("t1.in_ready_after_last", in_ready4, 1);

        // F + 1: carry ripples through every position
        acc4(4'hF, 4'h1, 1'b0);
        lit4(0, 31'h1, 3, 1, 0);
        lit4(1, 31'h2, 7, 1, 0);
        lit4(2, 31'h4, 15, 1, 0);
        lit4(3, 31'h8, 31, 1, 0);

        // F + F + 1: every monomial is set
        acc4(4'hF, 4'hF, 1'b1);
        for (int j = 0; j < 4; j++) begin
            cnt = (4 << j) - 1;
            lit4(j, 31'((64'd1 << cnt) - 1), cnt, 1, 1);
        end

        // backpressure on block 1: ready 1,0,0,1
        acc4(4'hF, 4'h1, 1'b0);
        @(posedge clk); #1 out_ready4 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("bp.stall_idx", idx4, 1);
            chk("bp.stall_terms", terms4, 31'h2);
            chk("bp.stall_count", count4, 7);
            @(posedge clk); #1;
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        chk("bp.resume_idx", idx4, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp.next_valid", out_valid4, 1);
        chk("bp.next_idx", idx4, 2);
        chk("bp.next_terms", terms4, 31'h4);

        // reset during block 2
        acc4(4'h7, 4'h6, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.idx_before", idx4, 2);
        rst = 1'b1;
        q4.delete();
        #1;
        chk("mid.valid", out_valid4, 0);
        chk("mid.in_ready", in_ready4, 1);
        chk("mid.terms", terms4, 0);
        chk("mid.idx", idx4, 0);
        chk("mid.sum", sum4, 0);
        @(posedge clk); #1 rst = 1'b0;
        acc4(4'h0, 4'h0, 1'b1);
        lit4(0, 31'h0, 3, 0, 1);

        for (int i = 0; i < 20; i++) begin
            acc4(4'($urandom), 4'($urandom), 1'($urandom));
            drain4();
        end
        for (int i = 0; i < 30; i++) begin
            acc7(7'($urandom), 7'($urandom), 1'($urandom));
            drain7();
        end

        repeat (3) @(posedge clk);
        chk("d4.queue_drained", q4.size(), 0);
        chk("d7.queue_drained", q7.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/gen_nonlinear_stream.md
Name: gen_nonlinear_stream

Overview:
- Sequential, handshaked successor of the combinational adder nonlinear-term generator.
- Accepts one adder operand set (a, b, carry-in c) and then streams the carry-chain monomials one bit-position block per handshake, from the LSB up.
- Each block also carries that position's carry-out (XOR of its terms) and its sum bit, so the stream doubles as a serial adder for self-checking the term expansion.
- Sits between the operand source and the analysis/collection logic. A run length selects how many blocks are emitted.

Parameters:
- NBIT, 7, adder operand width.
- NBLK, NBIT, number of blocks emitted per operand set. Legal range 1..NBIT; NBIT-1 reproduces the legacy truncated term set.
- WMAX, 2**(NBLK+1)-1, width of the term bus. Equals the size of the largest block. Derived; not to be overridden.
- CW, $clog2(WMAX+1), width of the term-count field.
- IW, $clog2(NBLK) (minimum 1), width of the block index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- a  in  NBIT  adder operand A.
- b  in  NBIT  adder operand B.
- c  in  1  carry-in.
- out_valid  out  1  block j is presented.
- out_ready  in  1  consumer accepts block j.
- out_terms  out  WMAX  terms of block j, LSB-packed; unused bits are 0.
- out_count  out  CW  number of valid terms in block j: 2**(j+2)-1.
- out_idx  out  IW  block index j.
- out_last  out  1  j == NBLK-1.
- out_carry  out  1  XOR of out_terms, i.e. carry into bit j+1.
- out_sum  out  1  a[j] ^ b[j] ^ carry into bit j.

Behaviour:
- Reset is asynchronous and active-high. While rst is asserted and after release:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - out_terms, out_count, out_idx, out_last, out_carry and out_sum are all 0;
  - the internal prev register and the a/b/c registers are cleared.
- States are IDLE and RUN.
- in_ready = (state == IDLE). It is combinational from state.
- IDLE: when in_valid is high, register a, b, c and load prev = {0…, c} with prev_count = 1. Then set j = 0 and go to RUN.
- RUN: out_valid = 1. Block j is formed combinationally from the registered a[j], b[j], prev and s = prev_count:
  - term[0] = a[j] & b[j];
  - term[1+k] = a[j] & prev[k] for k = 0..s-1;
  - term[1+s+k] = b[j] & prev[k] for k = 0..s-1;
  - all bits ≥ 2s+1 are 0;
  - out_count = 2s+1;
  - out_carry = ^out_terms;
  - out_sum = a[j] ^ b[j] ^ (^prev).
- On out_valid & out_ready:
  - not last: prev <= out_terms, prev_count <= out_count, j <= j+1;
  - last: return to IDLE and clear out_idx.
- Latency:
  - block 0 is valid the cycle after input acceptance;
  - with out_ready held high, one block is emitted per cycle;
  - one operand set takes NBLK+1 cycles in total (1 accept + NBLK blocks).
- Back-to-back operation:
  - in_ready rises the cycle after the last block is accepted;
  - there is no overlap between operand sets.
- Backpressure: while out_valid & !out_ready, every out_* field holds stable and nothing advances.
- Input stability:
  - in_valid in RUN is ignored; the operands are not sampled;
  - input fields need only be stable in the accept cycle.
- Width rule: prev is WMAX wide, and the top bits of block j are forced to 0. Block NBLK-1 exactly fills WMAX.
- Reset mid-run: the run aborts immediately and all state returns to reset values. No partial block is emitted after release.
- Term order matches the legacy combinational generator. Concatenating blocks 0..NBLK-1 (each out_count bits) reproduces its flat output vector for the same NBLK.

Test Plan:
- NBIT=NBLK=4, a=1, b=1, c=0, out_ready=1:
  - block0: terms=3'b001, count 3, carry 1, sum 0;
  - block1: terms=0, count 7, carry 0, sum 1;
  - blocks 2 and 3: sum 0;
  - 4 blocks on consecutive cycles, out_last only on block 3.
- NBIT=NBLK=4, a=4'hF, b=4'h1, c=0:
  - block0: terms 3'b001, carry 1, sum 0;
  - block1: terms 7'h02, carry 1, sum 0;
  - blocks 2 and 3: sum 0;
  - final out_carry = 1, so the sum bits plus the final carry give 0x10.
- NBIT=NBLK=4, a=b=4'hF, c=1:
  - every block is all-ones over out_count (3, 7, 15, 31);
  - out_carry = 1 and out_sum = 1 every block (0x1F).
- Backpressure: out_ready toggled 1,0,0,1 on block1. out_* stays constant during the two stall cycles, and block2 follows exactly one cycle after the resumed handshake.
- Reset mid-run: assert rst during block2 of a run.
  - Same cycle: out_valid = 0 and in_ready = 1.
  - Next operand set a=0, b=0, c=1 gives block0 terms=0, carry 0, sum 1, proving prev was cleared.
- NBIT=7, NBLK=6, randomized operands: concatenated blocks match the reference term model, and the sum bits match (a+b+c)[5:0].
